// File: rtl/gerenciador_maquinas.sv
// Purpose: grants machine run requests round-robin, caps simultaneous contactors, staggers starts.
// Latency: request-to-grant 1 cycle minimum (READY, slot free); request-to-release 1 cycle.
// Backpressure: none; an ungranted request stays pending as a level until a slot and READY coincide.
module gerenciador_maquinas #(
  parameter  int N_MAQ     = 4,
  parameter  int MAX_ON    = 2,
  parameter  int START_GAP = 3,
  localparam int CW        = $clog2(N_MAQ + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_MAQ-1:0] m,
  input  logic             parada,
  output logic [N_MAQ-1:0] c,
  output logic [CW-1:0]    n_on,
  output logic             lotado,
  output logic             espera
);

  localparam int PW = $clog2(N_MAQ);
  localparam int GW = (START_GAP > 1) ? $clog2(START_GAP) : 1;

  typedef enum logic [1:0] {READY, GAP, STOP} state_t;

  state_t           state, state_nx;
  logic [PW-1:0]    ptr, ptr_nx;
  logic [GW-1:0]    gap_cnt, gap_nx;
  logic [N_MAQ-1:0] c_nx;
  logic [N_MAQ-1:0] keep;
  logic [N_MAQ-1:0] pend;
  logic [CW-1:0]    keep_cnt;
  logic [CW-1:0]    c_cnt;
  logic             found;
  logic [PW-1:0]    sel;
  logic [PW-1:0]    idx;

  function automatic logic [CW-1:0] popcnt(input logic [N_MAQ-1:0] v);
    logic [CW-1:0] s;
    s = '0;
    for (int i = 0; i < N_MAQ; i++) s = s + CW'(v[i]);
    return s;
  endfunction

  // Releases are immediate; anything requested but not already on is pending.
  assign keep     = c & m;
  assign pend     = m & ~keep;
  assign keep_cnt = popcnt(keep);
  assign c_cnt    = popcnt(c_nx);

  // Round-robin pick: first pending bit at or after ptr, wrapping around.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int i = 0; i < N_MAQ; i++) begin
      idx = PW'((int'(ptr) + i) % N_MAQ);
      if (!found && pend[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  // Next-state: stop has priority, stop exit is an idle edge, else release/grant/gap countdown.
  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    gap_nx   = gap_cnt;
    c_nx     = keep;
    if (parada) begin
      state_nx = STOP;
      gap_nx   = '0;
      c_nx     = '0;
    end else if (state == STOP) begin
      state_nx = READY;
      c_nx     = '0;
    end else if (state == READY && keep_cnt < CW'(MAX_ON) && found) begin
      c_nx   = keep | ({{(N_MAQ-1){1'b0}}, 1'b1} << sel);
      ptr_nx = (sel == PW'(N_MAQ - 1)) ? '0 : sel + PW'(1);
      if (START_GAP > 1) begin
        state_nx = GAP;
        gap_nx   = GW'(START_GAP - 1);
      end
    end else if (state == GAP) begin
      gap_nx = gap_cnt - GW'(1);
      if (gap_cnt <= GW'(1)) state_nx = READY;
    end
  end

  // State and outputs; status flags come from next-state values so they match c.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= READY;
      ptr     <= '0;
      gap_cnt <= '0;
      c       <= '0;
      n_on    <= '0;
      lotado  <= 1'b0;
      espera  <= 1'b0;
    end else begin
      state   <= state_nx;
      ptr     <= ptr_nx;
      gap_cnt <= gap_nx;
      c       <= c_nx;
      n_on    <= c_cnt;
      lotado  <= (c_cnt == CW'(MAX_ON));
      espera  <= (state_nx == GAP);
    end
  end

endmodule

// File: tb/tb_gerenciador_maquinas.sv
// Purpose: checks gerenciador_maquinas (default and 8-machine configs) by vectors, sequences and a model.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: not applicable; stimulus is free-running.
module tb_gerenciador_maquinas;

  localparam int MAXON = 2;
  localparam int GAPC  = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] m;
  logic       parada;
  logic [3:0] c;
  logic [2:0] n_on;
  logic       lotado;
  logic       espera;

  logic [7:0] m8;
  logic       parada8;
  logic [7:0] c8;
  logic [3:0] n_on8;
  logic       lotado8;
  logic       espera8;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  gerenciador_maquinas u_dut (
    .clk(clk), .rst_n(rst_n), .m(m), .parada(parada),
    .c(c), .n_on(n_on), .lotado(lotado), .espera(espera)
  );

  gerenciador_maquinas #(.N_MAQ(8), .MAX_ON(8), .START_GAP(1)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .m(m8), .parada(parada8),
    .c(c8), .n_on(n_on8), .lotado(lotado8), .espera(espera8)
  );

  typedef struct {
    logic       rst_n;
    logic [3:0] m;
    logic       parada;
    logic [3:0] c;
    logic [2:0] n;
    logic       l;
    logic       e;
  } vec_t;

  vec_t tbl[$];

  // Reference model state: which machines are on, rotating pointer, cycles left before a new grant.
  logic [3:0] mdl_on;
  int         mdl_ptr;
  int         mdl_cool;
  bit         mdl_stop;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic add(input logic r, input logic [3:0] mm, input logic p,
                     input logic [3:0] ec, input logic [2:0] en, input logic el, input logic ee);
    vec_t v;
    v.rst_n = r; v.m = mm; v.parada = p; v.c = ec; v.n = en; v.l = el; v.e = ee;
    tbl.push_back(v);
  endtask

  task automatic model_step(input logic r, input logic [3:0] mm, input logic p);
    logic [3:0] keep;
    logic [3:0] pend;
    bit         granted;
    int         j;
    if (!r) begin
      mdl_on = '0; mdl_ptr = 0; mdl_cool = 0; mdl_stop = 0;
    end else if (p) begin
      mdl_on = '0; mdl_cool = 0; mdl_stop = 1;
    end else if (mdl_stop) begin
      mdl_stop = 0; mdl_on = '0;
    end else begin
      keep    = mdl_on & mm;
      pend    = mm & ~keep;
      granted = 0;
      if (mdl_cool == 0 && $countones(keep) < MAXON && pend != 0) begin
        for (int i = 0; i < 4; i++) begin
          j = (mdl_ptr + i) % 4;
          if (!granted && pend[j]) begin
            keep[j] = 1'b1;
            mdl_ptr = (j + 1) % 4;
            granted = 1;
          end
        end
        mdl_cool = GAPC - 1;
      end else if (mdl_cool > 0) begin
        mdl_cool--;
      end
      mdl_on = keep;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1);
  end

  // Stimulus and checking.
  initial begin
    int bitsel;
    int r;
    int exp8;
    rst_n = 1'b0; m = 4'hF; parada = 1'b0; m8 = '0; parada8 = 1'b0;

    // Reset, stagger/cap, round-robin, same-edge swaps, emergency stop, reset mid-operation.
    add(0, 4'hF, 0, 4'h0, 0, 0, 0);
    add(0, 4'hF, 0, 4'h0, 0, 0, 0);
    add(1, 4'hF, 0, 4'h1, 1, 0, 1);
    add(1, 4'hF, 0, 4'h1, 1, 0, 1);
    add(1, 4'hF, 0, 4'h1, 1, 0, 0);
    add(1, 4'hF, 0, 4'h3, 2, 1, 1);
    add(1, 4'hE, 0, 4'h2, 1, 0, 1);
    add(1, 4'hE, 0, 4'h2, 1, 0, 0);
    add(1, 4'hE, 0, 4'h6, 2, 1, 1);
    add(1, 4'hE, 0, 4'h6, 2, 1, 1);
    add(1, 4'hE, 0, 4'h6, 2, 1, 0);
    add(1, 4'hC, 0, 4'hC, 2, 1, 1);
    add(1, 4'hF, 0, 4'hC, 2, 1, 1);
    add(1, 4'hF, 0, 4'hC, 2, 1, 0);
    add(1, 4'h7, 0, 4'h5, 2, 1, 1);
    add(1, 4'h7, 0, 4'h5, 2, 1, 1);
    add(1, 4'h7, 0, 4'h5, 2, 1, 0);
    add(1, 4'h3, 0, 4'h3, 2, 1, 1);
    add(1, 4'h3, 0, 4'h3, 2, 1, 1);
    add(1, 4'h3, 0, 4'h3, 2, 1, 0);
    add(1, 4'hD, 0, 4'h5, 2, 1, 1);
    add(1, 4'hD, 1, 4'h0, 0, 0, 0);
    add(1, 4'hD, 0, 4'h0, 0, 0, 0);
    add(1, 4'hD, 0, 4'h8, 1, 0, 1);
    add(1, 4'hD, 0, 4'h8, 1, 0, 1);
    add(1, 4'hD, 0, 4'h8, 1, 0, 0);
    add(1, 4'hD, 0, 4'h9, 2, 1, 1);
    add(0, 4'hD, 0, 4'h0, 0, 0, 0);
    add(1, 4'hF, 0, 4'h1, 1, 0, 1);

    for (int k = 0; k < tbl.size(); k++) begin
      rst_n = tbl[k].rst_n; m = tbl[k].m; parada = tbl[k].parada;
      @(posedge clk); #1;
      chk($sformatf("vec%0d c", k), int'(c), int'(tbl[k].c));
      chk($sformatf("vec%0d n_on", k), int'(n_on), int'(tbl[k].n));
      chk($sformatf("vec%0d lotado", k), int'(lotado), int'(tbl[k].l));
      chk($sformatf("vec%0d espera", k), int'(espera), int'(tbl[k].e));
    end

    // Eight machines, no cap, no stagger: one new contactor per edge.
    rst_n = 1'b0; m = 4'h0; m8 = 8'h00;
    @(posedge clk); #1;
    chk("n8 reset c", int'(c8), 0);
    rst_n = 1'b1; m8 = 8'hFF;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      exp8 = (k >= 8) ? 255 : ((1 << k) - 1);
      chk($sformatf("n8 edge%0d c", k), int'(c8), exp8);
      chk($sformatf("n8 edge%0d n_on", k), int'(n_on8), (k >= 8) ? 8 : k);
      chk($sformatf("n8 edge%0d lotado", k), int'(lotado8), (k >= 8) ? 1 : 0);
      chk($sformatf("n8 edge%0d espera", k), int'(espera8), 0);
    end
    m8 = 8'h00;

    // Random traffic against the reference model.
    rst_n = 1'b0; m = 4'h0; parada = 1'b0;
    model_step(rst_n, m, parada);
    @(posedge clk); #1;
    chk("rnd reset c", int'(c), int'(mdl_on));
    for (int k = 0; k < 3000; k++) begin
      r      = $urandom_range(0, 199);
      rst_n  = (r != 0);
      parada = (r >= 1 && r <= 6);
      if ($urandom_range(0, 9) < 3) begin
        bitsel    = $urandom_range(0, 3);
        m[bitsel] = ~m[bitsel];
      end
      model_step(rst_n, m, parada);
      @(posedge clk); #1;
      chk("rnd c", int'(c), int'(mdl_on));
      chk("rnd n_on", int'(n_on), $countones(mdl_on));
      chk("rnd lotado", int'(lotado), ($countones(mdl_on) == MAXON) ? 1 : 0);
      chk("rnd espera", int'(espera), (mdl_cool > 0) ? 1 : 0);
      chk("rnd cap", (int'(n_on) <= MAXON) ? 1 : 0, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
